// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU:
// opcode and control-state encodings.
package cpu_pkg;

  localparam int AW = 6;
  localparam int DW = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDA  = 4'h2,
    OP_STA  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JNZ  = 4'hB,
    OP_ADDI = 4'hC,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_OPWAIT,
    S_ARG,
    S_ARGWAIT,
    S_EXEC,
    S_MEMWAIT,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Accumulator ALU: combines ACC with an
// immediate or memory operand, modulo 256.
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_t         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            zero
);

  always_comb begin
    result = a;
    unique case (op)
      OP_LDI,
      OP_LDA:  result = b;
      OP_ADD,
      OP_ADDI: result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu.sv
// Two-byte-instruction accumulator CPU on a
// registered single-port 64x8 memory bus.
module cpu
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic          rw,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  state_t        state;
  opcode_t       ir;
  logic [DW-1:0] acc;
  logic [DW-1:0] opr;
  logic [AW-1:0] pc;
  logic          z;

  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_y;
  logic          alu_z;
  logic          is_rd;
  logic          is_st;

  assign is_rd = ir inside {OP_LDA, OP_ADD,
                            OP_SUB, OP_AND,
                            OP_OR, OP_XOR};
  assign is_st = (ir == OP_STA);

  // Memory operand only arrives in MEMWAIT
  assign alu_b = (state == S_MEMWAIT)
               ? data_in : opr;

  cpu_alu u_alu (
    .op     (ir),
    .a      (acc),
    .b      (alu_b),
    .result (alu_y),
    .zero   (alu_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= OP_NOP;
      acc   <= '0;
      opr   <= '0;
      pc    <= '0;
      z     <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: state <= S_OPWAIT;
        S_OPWAIT: begin
          ir    <= opcode_t'(data_in[3:0]);
          pc    <= pc + 6'd1;
          state <= S_ARG;
        end
        S_ARG: state <= S_ARGWAIT;
        S_ARGWAIT: begin
          opr   <= data_in;
          pc    <= pc + 6'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (ir == OP_LDI || ir == OP_ADDI) begin
            acc <= alu_y;
            z   <= alu_z;
          end
          if (ir == OP_JMP ||
              (ir == OP_JZ && z) ||
              (ir == OP_JNZ && !z))
            pc <= opr[AW-1:0];
          if (is_rd)
            state <= S_MEMWAIT;
          if (ir == OP_HLT)
            state <= S_HALT;
        end
        S_MEMWAIT: begin
          acc   <= alu_y;
          z     <= alu_z;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    rw   = 1'b1;
    addr = pc;
    if (state == S_EXEC && (is_rd || is_st))
      addr = opr[AW-1:0];
    if (state == S_EXEC && is_st)
      rw = 1'b0;
  end

  assign data_out = acc;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: registered 64x8 RAM
// model plus per-cycle bus trace checks.
module tb_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rw;
  logic [5:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  logic [7:0] mem [64];
  logic [7:0] img [64];
  logic       ld = 1'b0;

  logic [5:0] t_addr [64];
  logic       t_rw   [64];
  logic [7:0] t_dout [64];

  int vectors = 0;
  int miscompares = 0;

  cpu dut (
    .clk      (clk),
    .reset    (reset),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      mem <= img;
    end else begin
      if (!rw) mem[addr] <= data_out;
      data_in <= mem[addr];
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
  endtask

  // load img with reset held, release at a negedge
  task automatic start();
    reset = 1'b1;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      t_addr[k] = addr;
      t_rw[k]   = rw;
      t_dout[k] = data_out;
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    int nw;
    clear_img();
    img[0] = 8'h01; img[1] = 8'h05;
    img[2] = 8'h03; img[3] = 8'h20;
    img[4] = 8'h0F; img[5] = 8'h00;
    start();
    run(25);
    nw = 0;
    for (int k = 0; k < 25; k++)
      if (!t_rw[k]) nw++;
    vectors++;
    if (nw !== 1) begin
      miscompares++;
      $display("FAIL st_nwrites: got %0d want 1", nw);
    end
    vectors++;
    if (t_rw[9] !== 1'b0 || t_addr[9] !== 6'h20 ||
        t_dout[9] !== 8'h05) begin
      miscompares++;
      $display("FAIL st_bus: got rw=%b a=%h d=%h want 0 20 05",
               t_rw[9], t_addr[9], t_dout[9]);
    end
    vectors++;
    if (t_addr[5] !== 6'h02) begin
      miscompares++;
      $display("FAIL st_fetch2: got %h want 02", t_addr[5]);
    end
    vectors++;
    if (t_rw[20] !== 1'b1 || t_addr[20] !== 6'h06 ||
        t_addr[24] !== 6'h06) begin
      miscompares++;
      $display("FAIL st_halt: got rw=%b a=%h/%h want 1 06/06",
               t_rw[20], t_addr[20], t_addr[24]);
    end
    vectors++;
    if (mem[6'h20] !== 8'h05) begin
      miscompares++;
      $display("FAIL st_mem: got %h want 05", mem[6'h20]);
    end
  endtask

  task automatic test_reset();
    // CPU is halted with ACC=05 here
    reset = 1'b1;
    #1;
    vectors++;
    if (rw !== 1'b1 || addr !== 6'h00 ||
        data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_state: got rw=%b a=%h d=%h want 1 00 00",
               rw, addr, data_out);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rw !== 1'b1 || addr !== 6'h00 ||
        data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_hold: got rw=%b a=%h d=%h want 1 00 00",
               rw, addr, data_out);
    end
  endtask

  task automatic test_addi_jz();
    clear_img();
    img[0] = 8'h01; img[1] = 8'hFF;
    img[2] = 8'h0C; img[3] = 8'h01;
    img[4] = 8'h0A; img[5] = 8'h10;
    img[6] = 8'h0F;
    img[16] = 8'hF0 | 8'h0F;
    start();
    run(25);
    vectors++;
    if (t_dout[5] !== 8'hFF) begin
      miscompares++;
      $display("FAIL ldi_ff: got %h want ff", t_dout[5]);
    end
    vectors++;
    if (t_dout[10] !== 8'h00) begin
      miscompares++;
      $display("FAIL addi_wrap: got %h want 00", t_dout[10]);
    end
    vectors++;
    if (t_addr[15] !== 6'h10) begin
      miscompares++;
      $display("FAIL jz_taken: got %h want 10", t_addr[15]);
    end
    vectors++;
    if (t_addr[22] !== 6'h12 || t_rw[22] !== 1'b1) begin
      miscompares++;
      $display("FAIL jz_halt: got a=%h rw=%b want 12 1",
               t_addr[22], t_rw[22]);
    end
  endtask

  task automatic test_and_mem();
    clear_img();
    img[0] = 8'h01; img[1] = 8'h3C;
    img[2] = 8'h06; img[3] = 8'h18;
    img[4] = 8'h0F;
    img[24] = 8'h0F;
    start();
    run(16);
    vectors++;
    if (t_addr[9] !== 6'h18 || t_rw[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL and_rd: got a=%h rw=%b want 18 1",
               t_addr[9], t_rw[9]);
    end
    vectors++;
    if (t_dout[10] !== 8'h3C) begin
      miscompares++;
      $display("FAIL and_wait: got %h want 3c", t_dout[10]);
    end
    vectors++;
    if (t_dout[11] !== 8'h0C) begin
      miscompares++;
      $display("FAIL and_res: got %h want 0c", t_dout[11]);
    end
    vectors++;
    if (t_addr[11] !== 6'h04) begin
      miscompares++;
      $display("FAIL and_6cyc: got %h want 04", t_addr[11]);
    end
  endtask

  task automatic test_sub_jnz();
    clear_img();
    img[0] = 8'h01; img[1] = 8'h00;
    img[2] = 8'h05; img[3] = 8'h20;
    img[4] = 8'h0B; img[5] = 8'h30;
    img[6] = 8'h0F;
    img[32] = 8'h01;
    img[48] = 8'h0F;
    start();
    run(20);
    vectors++;
    if (t_dout[11] !== 8'hFF) begin
      miscompares++;
      $display("FAIL sub_res: got %h want ff", t_dout[11]);
    end
    vectors++;
    if (t_addr[16] !== 6'h30) begin
      miscompares++;
      $display("FAIL jnz_taken: got %h want 30", t_addr[16]);
    end
  endtask

  task automatic test_reset_sta();
    clear_img();
    img[0] = 8'h01; img[1] = 8'h55;
    img[2] = 8'h03; img[3] = 8'h21;
    img[4] = 8'h0F;
    start();
    run(9);
    #1;
    vectors++;
    if (rw !== 1'b0 || addr !== 6'h21) begin
      miscompares++;
      $display("FAIL rsta_pre: got rw=%b a=%h want 0 21", rw, addr);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (rw !== 1'b1 || addr !== 6'h00 ||
        data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rsta_abort: got rw=%b a=%h d=%h want 1 00 00",
               rw, addr, data_out);
    end
    @(negedge clk);
    vectors++;
    if (mem[6'h21] !== 8'h00) begin
      miscompares++;
      $display("FAIL rsta_nowr: got %h want 00", mem[6'h21]);
    end
    reset = 1'b0;
    run(6);
    vectors++;
    if (t_addr[0] !== 6'h00 || t_addr[5] !== 6'h02) begin
      miscompares++;
      $display("FAIL rsta_restart: got %h/%h want 00/02",
               t_addr[0], t_addr[5]);
    end
  endtask

  task automatic test_pc_wrap();
    clear_img();
    // high nibble of opcode and OPR[7:6] must be ignored
    img[0] = 8'hA9; img[1] = 8'hFE;
    img[62] = 8'h00; img[63] = 8'h00;
    start();
    run(16);
    vectors++;
    if (t_addr[5] !== 6'h3E || t_addr[7] !== 6'h3F) begin
      miscompares++;
      $display("FAIL jmp_3e: got %h/%h want 3e/3f",
               t_addr[5], t_addr[7]);
    end
    vectors++;
    if (t_addr[10] !== 6'h00 || t_addr[15] !== 6'h3E) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h/%h want 00/3e",
               t_addr[10], t_addr[15]);
    end
  endtask

  initial begin
    test_store();
    test_reset();
    test_addi_jz();
    test_and_mem();
    test_sub_jnz();
    test_reset_sta();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
